fpu_issue_ctrl: RTL and testbench

FPU_ISSUE_CTRL -- requirements
Module: fpu_issue_ctrl

---
 rtl/fpu_pkg.sv | 34 +++
 rtl/fpu_cmd_fifo.sv | 64 ++++++
 rtl/fpu_issue_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_fpu_issue_ctrl.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// Shared FPU issue-path definitions: opcodes, FSM encoding, float word and command types.
package fpu_pkg;

   typedef logic [31:0] fp32_t;

   localparam logic [4:0] OP_NOP = 5'b00000;
   localparam logic [4:0] OP_ADD = 5'b00010;
   localparam logic [4:0] OP_SUB = 5'b00011;
   localparam logic [4:0] OP_MUL = 5'b00100;
   localparam logic [4:0] OP_DIV = 5'b01000;
   localparam logic [4:0] OP_CMP = 5'b10000;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_DONE  = 2'd3
   } issue_state_e;

   // One queued command: 32 + 32 + 5 = 69 bits
   typedef struct packed {
      fp32_t      a;
      fp32_t      b;
      logic [4:0] opcode;
   } fpu_cmd_t;

   localparam int CMD_W = $bits(fpu_cmd_t);

   function automatic logic op_legal(input logic [4:0] op);
      return (op == OP_ADD) || (op == OP_SUB) || (op == OP_MUL) ||
             (op == OP_DIV) || (op == OP_CMP);
   endfunction

endpackage

// File: rtl/fpu_cmd_fifo.sv
// Command FIFO: DEPTH entries (power of two), first-in first-out, no full bypass.
module fpu_cmd_fifo
   import fpu_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_en,
   input  logic [CMD_W-1:0] wr_data,
   input  logic             rd_en,
   output logic [CMD_W-1:0] rd_data,
   output logic             full,
   output logic             empty
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [CMD_W-1:0] mem_q [DEPTH];
   logic [CMD_W-1:0] mem_d [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [AW:0]      count_q, count_d;
   logic             do_wr, do_rd;

   assign full    = (count_q == (AW+1)'(DEPTH));
   assign empty   = (count_q == '0);
   assign rd_data = mem_q[rd_ptr_q];
   assign do_wr   = wr_en && !full;
   assign do_rd   = rd_en && !empty;

   // Next-state: pointers wrap naturally at DEPTH since DEPTH is a power of two
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_wr) begin
         mem_d[wr_ptr_q] = wr_data;
         wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (do_rd) rd_ptr_d = rd_ptr_q + AW'(1);
      case ({do_wr, do_rd})
         2'b10:   count_d = count_q + (AW+1)'(1);
         2'b01:   count_d = count_q - (AW+1)'(1);
         default: count_d = count_q;
      endcase
   end

   // State registers; reset flushes the queue
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         mem_q    <= mem_d;
      end
   end

endmodule

// File: rtl/fpu_issue_ctrl.sv
// FPU issue controller: queues commands, issues one at a time to an ALU with fixed
// latency ALU_LAT, captures the result and holds it until consumed.
// Optional feature macro: FPU_ISSUE_PERF_EN adds saturating issued/illegal counters.
module fpu_issue_ctrl
   import fpu_pkg::*;
#(
   parameter int DEPTH   = 4,
   parameter int ALU_LAT = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [31:0] cmd_a,
   input  logic [31:0] cmd_b,
   input  logic [4:0]  cmd_opcode,
   output logic [31:0] alu_a,
   output logic [31:0] alu_b,
   output logic [4:0]  alu_opcode,
   input  logic [31:0] alu_op,
   input  logic        alu_gr,
   input  logic        alu_lr,
   input  logic        alu_eq,
   output logic        res_valid,
   input  logic        res_ready,
   output logic [31:0] res_data,
   output logic        res_gr,
   output logic        res_lr,
   output logic        res_eq,
   output logic        res_err
`ifdef FPU_ISSUE_PERF_EN
   ,
   output logic [31:0] perf_issued,
   output logic [15:0] perf_illegal
`endif
);

   localparam int CW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
   localparam logic [CW-1:0] CNT_INIT = CW'(ALU_LAT - 1);

   issue_state_e     state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   fp32_t            alu_a_q, alu_a_d, alu_b_q, alu_b_d, res_data_q, res_data_d;
   logic [4:0]       alu_opc_q, alu_opc_d;
   logic             res_gr_q, res_gr_d, res_lr_q, res_lr_d, res_eq_q, res_eq_d;
   logic             res_err_q, res_err_d;
   logic             fifo_full, fifo_empty, pop, pop_legal, pop_illegal;
   logic [CMD_W-1:0] fifo_wdata, fifo_rdata;
   fpu_cmd_t         head;

   assign cmd_ready  = !fifo_full;
   assign fifo_wdata = {cmd_a, cmd_b, cmd_opcode};
   assign head       = fifo_rdata;

   fpu_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (cmd_valid && cmd_ready),
      .wr_data (fifo_wdata),
      .rd_en   (pop),
      .rd_data (fifo_rdata),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   assign alu_a      = alu_a_q;
   assign alu_b      = alu_b_q;
   assign alu_opcode = alu_opc_q;
   assign res_valid  = (state_q == ST_DONE);
   assign res_data   = res_data_q;
   assign res_gr     = res_gr_q;
   assign res_lr     = res_lr_q;
   assign res_eq     = res_eq_q;
   assign res_err    = res_err_q;

   // Issue FSM: pop only from IDLE so a single operation is ever in flight
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      alu_a_d     = alu_a_q;
      alu_b_d     = alu_b_q;
      alu_opc_d   = alu_opc_q;
      res_data_d  = res_data_q;
      res_gr_d    = res_gr_q;
      res_lr_d    = res_lr_q;
      res_eq_d    = res_eq_q;
      res_err_d   = res_err_q;
      pop         = 1'b0;
      pop_legal   = 1'b0;
      pop_illegal = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (!fifo_empty) begin
               pop = 1'b1;
               if (op_legal(head.opcode)) begin
                  pop_legal = 1'b1;
                  alu_a_d   = head.a;
                  alu_b_d   = head.b;
                  alu_opc_d = head.opcode;
                  state_d   = ST_ISSUE;
               end else begin
                  // Illegal op bypasses the ALU entirely
                  pop_illegal = 1'b1;
                  res_data_d  = '0;
                  res_gr_d    = 1'b0;
                  res_lr_d    = 1'b0;
                  res_eq_d    = 1'b0;
                  res_err_d   = 1'b1;
                  state_d     = ST_DONE;
               end
            end
         end
         ST_ISSUE: begin
            cnt_d   = CNT_INIT;
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            if (cnt_q == '0) begin
               res_data_d = alu_op;
               res_gr_d   = alu_gr;
               res_lr_d   = alu_lr;
               res_eq_d   = alu_eq;
               res_err_d  = 1'b0;
               alu_opc_d  = OP_NOP;
               state_d    = ST_DONE;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         ST_DONE: begin
            if (res_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Control and datapath registers; reset discards any in-flight or pending result
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         alu_a_q    <= '0;
         alu_b_q    <= '0;
         alu_opc_q  <= OP_NOP;
         res_data_q <= '0;
         res_gr_q   <= 1'b0;
         res_lr_q   <= 1'b0;
         res_eq_q   <= 1'b0;
         res_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         alu_a_q    <= alu_a_d;
         alu_b_q    <= alu_b_d;
         alu_opc_q  <= alu_opc_d;
         res_data_q <= res_data_d;
         res_gr_q   <= res_gr_d;
         res_lr_q   <= res_lr_d;
         res_eq_q   <= res_eq_d;
         res_err_q  <= res_err_d;
      end
   end

`ifdef FPU_ISSUE_PERF_EN
   logic [31:0] perf_issued_q, perf_issued_d;
   logic [15:0] perf_illegal_q, perf_illegal_d;

   assign perf_issued  = perf_issued_q;
   assign perf_illegal = perf_illegal_q;

   // Saturating event counters
   always_comb begin
      perf_issued_d  = perf_issued_q;
      perf_illegal_d = perf_illegal_q;
      if (pop_legal && !(&perf_issued_q))    perf_issued_d  = perf_issued_q + 32'd1;
      if (pop_illegal && !(&perf_illegal_q)) perf_illegal_d = perf_illegal_q + 16'd1;
   end

   // Counter registers
   always_ff @(posedge clk) begin
      if (rst) begin
         perf_issued_q  <= '0;
         perf_illegal_q <= '0;
      end else begin
         perf_issued_q  <= perf_issued_d;
         perf_illegal_q <= perf_illegal_d;
      end
   end
`endif

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Directed bench for fpu_issue_ctrl with a 2-cycle stub ALU.
module tb_fpu_issue_ctrl;
   import fpu_pkg::*;

   localparam int DEPTH = 4;
   localparam logic [31:0] A0 = 32'hC0700000;  // -3.75
   localparam logic [31:0] B0 = 32'h3FC00000;  //  1.5

   logic        clk = 1'b0;
   logic        rst, cmd_valid, cmd_ready, res_valid, res_ready;
   logic [31:0] cmd_a, cmd_b, alu_a, alu_b, alu_op, res_data;
   logic [4:0]  cmd_opcode, alu_opcode;
   logic        alu_gr, alu_lr, alu_eq, res_gr, res_lr, res_eq, res_err;
`ifdef FPU_ISSUE_PERF_EN
   logic [31:0] perf_issued;
   logic [15:0] perf_illegal;
`endif

   int n_chk = 0;
   int n_fail = 0;
   int nz_alu_cnt = 0;

   always #5 clk = ~clk;

   fpu_issue_ctrl #(.DEPTH(DEPTH), .ALU_LAT(2)) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_opcode(cmd_opcode),
      .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode),
      .alu_op(alu_op), .alu_gr(alu_gr), .alu_lr(alu_lr), .alu_eq(alu_eq),
      .res_valid(res_valid), .res_ready(res_ready),
      .res_data(res_data), .res_gr(res_gr), .res_lr(res_lr), .res_eq(res_eq),
      .res_err(res_err)
`ifdef FPU_ISSUE_PERF_EN
      , .perf_issued(perf_issued), .perf_illegal(perf_illegal)
`endif
   );

   // Stub ALU: known answers for the reference operands, else a tagged xor
   function automatic logic [34:0] alu_f(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
      if (a == A0 && b == B0) begin
         case (op)
            OP_ADD:  return {3'b000, 32'hC0100000};
            OP_SUB:  return {3'b000, 32'hC0A80000};
            OP_MUL:  return {3'b000, 32'hC0B40000};
            OP_DIV:  return {3'b000, 32'hC0200000};
            OP_CMP:  return {3'b010, 32'h0};
            default: return '0;
         endcase
      end
      return {3'b000, a ^ b ^ {27'd0, op}};
   endfunction

   // Two-stage pipe models ALU_LAT=2: output is valid two edges after inputs settle
   logic [34:0] s1, s2;
   always @(posedge clk) begin
      s1 <= alu_f(alu_opcode, alu_a, alu_b);
      s2 <= s1;
      if (alu_opcode != 5'd0) nz_alu_cnt <= nz_alu_cnt + 1;
   end
   assign {alu_gr, alu_lr, alu_eq, alu_op} = s2;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   // Drive one command; returns #1 after the accepting edge with valid dropped
   task automatic push(input logic [31:0] a, input logic [31:0] b, input logic [4:0] op);
      int n = 0;
      cmd_a = a; cmd_b = b; cmd_opcode = op; cmd_valid = 1'b1;
      while (!cmd_ready && n < 100) begin
         @(posedge clk); #1; n++;
      end
      chk("push_ready", {31'd0, cmd_ready}, 32'd1);
      @(posedge clk); #1;
      cmd_valid = 1'b0;
   endtask

   // Wait for a result (bounded), check it, let the handshake edge pass
   task automatic get_res(input string tag, input logic [31:0] exp_d, input logic [2:0] exp_f, input logic exp_e);
      int n = 0;
      while (!res_valid && n < 50) begin
         @(posedge clk); #1; n++;
      end
      chk({tag, "_valid"}, {31'd0, res_valid}, 32'd1);
      chk({tag, "_data"}, res_data, exp_d);
      chk({tag, "_flags"}, {29'd0, res_gr, res_lr, res_eq}, {29'd0, exp_f});
      chk({tag, "_err"}, {31'd0, res_err}, {31'd0, exp_e});
      @(posedge clk); #1;
   endtask

   initial begin
      int first_v, hold, cnt0, vcount;
      logic [31:0] cap_d;
      logic        cap_e;
      rst = 1'b1; cmd_valid = 1'b0; cmd_a = '0; cmd_b = '0; cmd_opcode = '0; res_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      // Reset state
      chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
      chk("rst_res_valid", {31'd0, res_valid}, 32'd0);
      chk("rst_res_data", res_data, 32'd0);
      chk("rst_res_misc", {28'd0, res_gr, res_lr, res_eq, res_err}, 32'd0);
      chk("rst_alu", alu_a | alu_b | {27'd0, alu_opcode}, 32'd0);

      // Single ADD: opcode held 3 cycles, res_valid first sampled high at edge 5
      cmd_a = A0; cmd_b = B0; cmd_opcode = OP_ADD; cmd_valid = 1'b1;
      chk("lat_ready", {31'd0, cmd_ready}, 32'd1);
      @(posedge clk); #1;  // accepting edge (edge 0)
      cmd_valid = 1'b0;
      first_v = 0; hold = 0; cap_d = '0; cap_e = 1'b1;
      for (int e = 1; e <= 7; e++) begin
         // values here are what edge e samples
         if (res_valid && first_v == 0) begin
            first_v = e; cap_d = res_data; cap_e = res_err;
         end
         if (alu_opcode == OP_ADD) hold++;
         @(posedge clk); #1;
      end
      chk("lat_edge", first_v, 5);
      chk("lat_hold", hold, 3);
      chk("lat_data", cap_d, 32'hC0100000);
      chk("lat_err", {31'd0, cap_e}, 32'd0);
      chk("lat_idle_op", {27'd0, alu_opcode}, 32'd0);

      // Fill: DEPTH+1 accepts with the sink stalled, then drain in order
      res_ready = 1'b0;
      for (int i = 0; i < DEPTH + 1; i++) push(32'(i + 1), 32'd0, OP_ADD);
      chk("full_ready", {31'd0, cmd_ready}, 32'd0);
      repeat (4) @(posedge clk);
      #0;
      chk("stall_valid", {31'd0, res_valid}, 32'd1);
      chk("stall_data", res_data, 32'd1 ^ 32'd2);
      res_ready = 1'b1;
      for (int i = 0; i < DEPTH + 1; i++) get_res("drain", 32'(i + 1) ^ 32'd2, 3'b000, 1'b0);
      vcount = 0;
      for (int i = 0; i < 12; i++) begin
         if (res_valid) vcount++;
         @(posedge clk); #1;
      end
      chk("drain_extra", vcount, 0);
      chk("drain_ready", {31'd0, cmd_ready}, 32'd1);

      // Reset mid-WAIT with two commands queued
      push(A0, B0, OP_ADD);
      push(A0, B0, OP_SUB);
      push(A0, B0, OP_MUL);
      chk("pre_rst_alu", {27'd0, alu_opcode}, {27'd0, OP_ADD});
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("rst_mid_valid", {31'd0, res_valid}, 32'd0);
      chk("rst_mid_ready", {31'd0, cmd_ready}, 32'd1);
      chk("rst_mid_alu", {27'd0, alu_opcode}, 32'd0);
      vcount = 0;
      for (int i = 0; i < 20; i++) begin
         if (res_valid || alu_opcode != 5'd0) vcount++;
         @(posedge clk); #1;
      end
      chk("rst_no_stale", vcount, 0);

      // Back-to-back SUB/MUL/DIV/CMP, results in order, one per 5 cycles
      push(A0, B0, OP_SUB);
      push(A0, B0, OP_MUL);
      push(A0, B0, OP_DIV);
      push(A0, B0, OP_CMP);
      get_res("sub", 32'hC0A80000, 3'b000, 1'b0);
      cnt0 = 0;
      while (!res_valid && cnt0 < 50) begin
         @(posedge clk); #1; cnt0++;
      end
      chk("thru_gap", cnt0, 4);  // 1 handshake edge in get_res + 4 here = 5
      get_res("mul", 32'hC0B40000, 3'b000, 1'b0);
      get_res("div", 32'hC0200000, 3'b000, 1'b0);
      get_res("cmp", 32'h0, 3'b010, 1'b0);

      // Illegal opcode: error result, ALU never driven
      cnt0 = nz_alu_cnt;
      push(A0, B0, 5'b00001);
      get_res("ill", 32'h0, 3'b000, 1'b1);
      repeat (3) @(posedge clk);
      #1;
      chk("ill_alu_idle", nz_alu_cnt - cnt0, 0);

`ifdef FPU_ISSUE_PERF_EN
      chk("perf_issued", perf_issued, 32'd4);
      chk("perf_illegal", {16'd0, perf_illegal}, 32'd1);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
